sudoku_check_seq: RTL and testbench

Sequencing controller for the Sudoku check datapath. It accepts the 81 cell digits of a board as a serial stream of 4-bit hex values and packs them into the 324-bit hex bus that feeds the combinational `sudoku_hex2bin` converter. It then walks the returned 729-bit one-hot bus across all 27 constraint groups (9 rows, 9 columns, 9 boxes), one group per cycle, and reports a single pass/fail verdict.

---
 rtl/sudoku_check_seq.sv | 208 ++++++++++++++++++++
 tb/tb_sudoku_check_seq.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sudoku_check_seq.sv
// sudoku_check_seq: sequencing controller for the Sudoku check datapath.
//
// Accepts 81 cell digits row-major over a valid/ready stream and packs them into
// the hex bus feeding the external hex2bin converter. After a settle delay it walks
// the returned one-hot bus through all 27 constraint groups (rows, columns, boxes),
// one group per cycle, and reports a pass/fail verdict with a one-cycle done pulse.
//
// Optional feature macro: SUDOKU_ERRIDX_EN adds the err_group port (first failing
// group index, 5'd31 when none has failed).
//
// Ports:
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   abort       synchronous abort back to idle (highest priority)
//   cell_valid  cell stream valid
//   cell_ready  cell stream ready (idle/load only)
//   cell_data   digit 1..9, anything else is a blank/invalid cell
//   hex         packed board, cell i at hex[4i+3:4i]
//   bin         one-hot board from hex2bin, cell i at bin[9i+8:9i]
//   busy        high while loading, settling or checking
//   done        one-cycle verdict pulse
//   pass        board valid, held until the next accepted cell
//   err_group   first failing group (SUDOKU_ERRIDX_EN only)
module sudoku_check_seq #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort,
  input  logic         cell_valid,
  output logic         cell_ready,
  input  logic [3:0]   cell_data,
  output logic [323:0] hex,
  input  logic [728:0] bin,
  output logic         busy,
  output logic         done,
  output logic         pass
`ifdef SUDOKU_ERRIDX_EN
  ,
  output logic [4:0]   err_group
`endif
);

  localparam logic [6:0] LastCell   = 7'd80;
  localparam logic [4:0] LastGroup  = 5'd26;
  localparam logic [2:0] SettleLast = (SETTLE_CYCLES == 0) ? 3'd0 : 3'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StSettle,
    StCheck,
    StDone
  } state_e;

  state_e         state_q;
  logic [6:0]     cell_q;
  logic [2:0]     settle_q;
  logic [4:0]     grp_q;
  logic [323:0]   hex_q;
  logic           pass_q;
  logic           done_q;
`ifdef SUDOKU_ERRIDX_EN
  logic [4:0]     err_q;
`endif

  // Cell index (row*9 + col) of member k of group g.
  function automatic int group_cell(int g, int k);
    int b;
    b = g - 18;
    if (g < 9) begin
      return g * 9 + k;
    end else if (g < 18) begin
      return k * 9 + (g - 9);
    end
    return (3 * (b / 3) + k / 3) * 9 + 3 * (b % 3) + k % 3;
  endfunction

  function automatic logic is_onehot9(logic [8:0] s);
    return (s != 9'd0) && ((s & (s - 9'd1)) == 9'd0);
  endfunction

  // All 27 group verdicts are formed in parallel from bin; the walk selects one
  // per cycle. Upper bits are padding so any 5-bit index is in range.
  logic [31:0] group_ok;

  for (genvar g = 0; g < 27; g++) begin : g_group
    logic [8:0] or_acc;
    logic       slices_ok;

    always_comb begin
      or_acc    = '0;
      slices_ok = 1'b1;
      for (int k = 0; k < 9; k++) begin
        or_acc    = or_acc | bin[9 * group_cell(g, k) +: 9];
        slices_ok = slices_ok & is_onehot9(bin[9 * group_cell(g, k) +: 9]);
      end
    end

    // Exactly one bit per cell and full coverage means no blanks and no duplicates.
    assign group_ok[g] = slices_ok && (or_acc == 9'h1FF);
  end

  assign group_ok[31:27] = '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cell_q   <= '0;
      settle_q <= '0;
      grp_q    <= '0;
      hex_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SUDOKU_ERRIDX_EN
      err_q    <= 5'd31;
`endif
    end else if (abort) begin
      // hex_q and err_q are deliberately retained.
      state_q  <= StIdle;
      cell_q   <= '0;
      settle_q <= '0;
      grp_q    <= '0;
      pass_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StLoad: begin
          if (cell_valid) begin
            hex_q[{cell_q, 2'b00} +: 4] <= cell_data;
            if (state_q == StIdle) begin
              pass_q <= 1'b0;
`ifdef SUDOKU_ERRIDX_EN
              err_q  <= 5'd31;
`endif
            end
            if (cell_q == LastCell) begin
              cell_q <= '0;
              if (SETTLE_CYCLES == 0) begin
                state_q <= StCheck;
                grp_q   <= '0;
                pass_q  <= 1'b1;
              end else begin
                state_q  <= StSettle;
                settle_q <= '0;
              end
            end else begin
              cell_q  <= cell_q + 7'd1;
              state_q <= StLoad;
            end
          end
        end

        StSettle: begin
          if (settle_q == SettleLast) begin
            settle_q <= '0;
            grp_q    <= '0;
            pass_q   <= 1'b1;
            state_q  <= StCheck;
          end else begin
            settle_q <= settle_q + 3'd1;
          end
        end

        StCheck: begin
          if (!group_ok[grp_q]) begin
            pass_q <= 1'b0;
`ifdef SUDOKU_ERRIDX_EN
            // pass_q still high means this is the first failure.
            if (pass_q) begin
              err_q <= grp_q;
            end
`endif
          end
          if (grp_q == LastGroup) begin
            grp_q   <= '0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            grp_q <= grp_q + 5'd1;
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    cell_ready = (state_q == StIdle) || (state_q == StLoad);
    busy       = (state_q == StLoad) || (state_q == StSettle) || (state_q == StCheck);
  end

  assign hex  = hex_q;
  assign done = done_q;
  assign pass = pass_q;
`ifdef SUDOKU_ERRIDX_EN
  assign err_group = err_q;
`endif

endmodule

// File: tb/tb_sudoku_check_seq.sv
// tb_sudoku_check_seq: directed bench for sudoku_check_seq.
//
// A hex2bin stand-in drives bin from hex. A reference model built from the Sudoku
// rules (set membership per row/column/box) and a cycle timeline after the last
// cell predicts every output each cycle. err_group is checked only when
// SUDOKU_ERRIDX_EN is defined.
module tb_sudoku_check_seq;

  localparam int S = 1;

  typedef logic [3:0] board_t [81];

  logic         clk;
  logic         rst_n;
  logic         abort;
  logic         cell_valid;
  logic         cell_ready;
  logic [3:0]   cell_data;
  logic [323:0] hex;
  logic [728:0] bin;
  logic         busy;
  logic         done;
  logic         pass;
`ifdef SUDOKU_ERRIDX_EN
  logic [4:0]   err_group;
  logic [4:0]   err_at_done;
`endif

  int checks   = 0;
  int failures = 0;

  sudoku_check_seq #(
    .SETTLE_CYCLES (S)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .abort      (abort),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_data  (cell_data),
    .hex        (hex),
    .bin        (bin),
    .busy       (busy),
    .done       (done),
`ifdef SUDOKU_ERRIDX_EN
    .err_group  (err_group),
`endif
    .pass       (pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // hex2bin stand-in: digit d in 1..9 sets bit d-1 of the cell slice.
  always_comb begin
    bin = '0;
    for (int i = 0; i < 81; i++) begin
      if (hex[4*i +: 4] >= 4'd1 && hex[4*i +: 4] <= 4'd9) begin
        bin[9*i + int'(hex[4*i +: 4]) - 1] = 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [323:0] act, input logic [323:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // First group (0..26) violating the Sudoku rules, or 27 if the board is solved.
  function automatic int first_fail(input board_t b);
    int r, c, d;
    bit [9:0] seen;
    bit ok;
    for (int g = 0; g < 27; g++) begin
      seen = '0;
      ok   = 1'b1;
      for (int k = 0; k < 9; k++) begin
        if (g < 9) begin
          r = g; c = k;
        end else if (g < 18) begin
          r = k; c = g - 9;
        end else begin
          r = 3 * ((g - 18) / 3) + k / 3;
          c = 3 * ((g - 18) % 3) + k % 3;
        end
        d = int'(b[r*9 + c]);
        if (d < 1 || d > 9) ok = 1'b0;
        else if (seen[d]) ok = 1'b0;
        else seen[d] = 1'b1;
      end
      if (!ok) return g;
    end
    return 27;
  endfunction

  // Reference model state.
  int           n_acc;
  int           post;   // cycles since the 81st transfer, -1 when not in that phase
  int           ff;
  logic         mpass;
  logic [4:0]   merr;
  logic [323:0] mhex;
  board_t       mboard;

  always @(negedge clk) begin : cmp
    logic       e_ready, e_busy, e_done, e_pass;
    logic [4:0] e_err;
    int         c;
    if (!rst_n) begin
      n_acc = 0; post = -1; ff = 27; mpass = 1'b0; merr = 5'd31; mhex = '0;
    end
    if (post > 0) begin
      e_ready = 1'b0;
      c = post - S - 1;
      if (c < 0) begin
        e_busy = 1'b1; e_done = 1'b0; e_pass = mpass; e_err = merr;
      end else begin
        e_busy = (c < 27);
        e_done = (c == 27);
        e_pass = (ff >= c);
        e_err  = (ff < c) ? 5'(ff) : 5'd31;
      end
    end else begin
      e_ready = 1'b1; e_busy = (n_acc > 0); e_done = 1'b0; e_pass = mpass; e_err = merr;
    end
    check("cell_ready", cell_ready, e_ready);
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("pass", pass, e_pass);
    check("hex", hex, mhex);
`ifdef SUDOKU_ERRIDX_EN
    check("err_group", err_group, e_err);
`endif
    if (rst_n) begin
      if (abort) begin
        n_acc = 0; post = -1; mpass = 1'b0; merr = e_err;
      end else if (post > 0) begin
        if (post == S + 28) begin
          post = -1; mpass = e_pass; merr = e_err;
        end else begin
          post++;
        end
      end else if (cell_valid) begin
        mhex[4*n_acc +: 4] = cell_data;
        mboard[n_acc] = cell_data;
        if (n_acc == 0) begin
          mpass = 1'b0; merr = 5'd31;
        end
        if (n_acc == 80) begin
          n_acc = 0; post = 1; ff = first_fail(mboard);
        end else begin
          n_acc++;
        end
      end
    end
  end

  // Drives n cells of b starting at posedge+1; returns at posedge+1 after the last transfer.
  task automatic send_board(input board_t b, input int n, input bit gaps);
    int idx = 0;
    int cyc = 0;
    while (idx < n) begin
      cell_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      cell_data  = cell_valid ? b[idx] : 4'($urandom_range(0, 15));
      @(negedge clk);
      if (cell_valid && cell_ready) idx++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 1000) begin
        checks++; failures++;
        $display("FAIL load_timeout: got %0d transfers expected %0d", idx, n);
        break;
      end
    end
    // With gaps, keep offering junk while the block must not accept it.
    cell_valid = gaps;
    cell_data  = 4'h3;
  endtask

  // Counts cycles from the one after the last transfer (1) to the done cycle.
  task automatic wait_done(output int lat, output logic p);
    lat = 1;
    p   = 1'bx;
    while (1) begin
      @(negedge clk);
      if (done) begin
        p = pass;
`ifdef SUDOKU_ERRIDX_EN
        err_at_done = err_group;
`endif
        break;
      end
      @(posedge clk); #1;
      lat++;
      if (lat > 200) begin
        checks++; failures++;
        $display("FAIL done_timeout: got no done expected one within 200 cycles");
        break;
      end
    end
    @(posedge clk); #1;
    cell_valid = 1'b0;
  endtask

  board_t solved, blank44, swapped;
  int     lat;
  logic   p;

  initial begin
    rst_n = 1'b0; abort = 1'b0; cell_valid = 1'b0; cell_data = 4'd0;
    for (int r = 0; r < 9; r++) begin
      for (int c = 0; c < 9; c++) begin
        solved[r*9 + c] = 4'(((3 * (r % 3) + r / 3 + c) % 9) + 1);
      end
    end
    blank44 = solved;
    blank44[40] = 4'd0;
    swapped = solved;
    swapped[0] = solved[1];
    swapped[1] = solved[0];

    check("model_solved", first_fail(solved), 27);
    check("model_blank44", first_fail(blank44), 4);
    check("model_swapped", first_fail(swapped), 9);

    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", cell_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_hex", hex, 0);
    check("rst_pass", pass, 0);
    check("rst_done", done, 0);
`ifdef SUDOKU_ERRIDX_EN
    check("rst_err", err_group, 31);
`endif
    rst_n = 1'b1;

    // Solved board, valid held high.
    send_board(solved, 81, 1'b0);
    wait_done(lat, p);
    check("t1_latency", lat, 29);
    check("t1_pass", p, 1);
`ifdef SUDOKU_ERRIDX_EN
    check("t1_err", err_at_done, 31);
`endif

    // Centre blank, back-to-back.
    send_board(blank44, 81, 1'b0);
    wait_done(lat, p);
    check("t2_pass", p, 0);
`ifdef SUDOKU_ERRIDX_EN
    check("t2_err", err_at_done, 4);
`endif

    // Swap within row 0: first failure is column 0.
    send_board(swapped, 81, 1'b0);
    wait_done(lat, p);
    check("t3_pass", p, 0);
`ifdef SUDOKU_ERRIDX_EN
    check("t3_err", err_at_done, 9);
`endif

    // Random valid gaps, valid kept high through settle/check.
    send_board(solved, 81, 1'b1);
    wait_done(lat, p);
    check("t4_latency", lat, 29);
    check("t4_pass", p, 1);
    check("t4_hex", hex, mhex);

    // Abort after 40 transfers, then a full board.
    send_board(swapped, 40, 1'b0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("t5_abort_busy", busy, 0);
    check("t5_abort_pass", pass, 0);
    repeat (5) begin @(posedge clk); #1; end
    send_board(solved, 81, 1'b0);
    wait_done(lat, p);
    check("t5_pass", p, 1);

    // Abort mid-check: no done may follow (model watches for it).
    send_board(solved, 81, 1'b0);
    repeat (S + 5) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (40) begin @(posedge clk); #1; end

    // Asynchronous reset during check group 10.
    send_board(blank44, 81, 1'b0);
    repeat (S + 10) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", busy, 0);
    check("t6_rst_ready", cell_ready, 1);
    check("t6_rst_hex", hex, 0);
    check("t6_rst_pass", pass, 0);
    check("t6_rst_done", done, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_board(solved, 81, 1'b0);
    wait_done(lat, p);
    check("t6_latency", lat, 29);
    check("t6_pass", p, 1);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

endmodule
